// File: rtl/pc_out_framer.sv
`timescale 1ns/1ps
// Splits packed PC words: route==0 words go through a host FIFO into fixed-length
// host blocks, nonzero-route words pass straight to route_out. Define PC_OUT_FRAMER_PAD_EN
// to pad a stalled partial block with NOP words after an idle timeout.
module pc_out_framer #(
    parameter int unsigned NPCcode  = 8,
    parameter int unsigned NPCdata  = 24,
    parameter int unsigned NPCroute = 11,
    parameter int unsigned NBlock   = 16,
    parameter int unsigned NTimeout = 1024,
    parameter int unsigned NFifo    = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NPCroute+NPCcode+NPCdata-1:0]   PC_in_d,
    input  logic                                  PC_in_v,
    output logic                                  PC_in_a,
    output logic [NPCcode+NPCdata-1:0]            host_out_d,
    output logic                                  host_out_v,
    input  logic                                  host_out_a,
    output logic [NPCroute+NPCcode+NPCdata-1:0]   route_out_d,
    output logic                                  route_out_v,
    input  logic                                  route_out_a,
    output logic [15:0]                           pad_count
);

    localparam int unsigned HW = NPCcode + NPCdata;
    localparam int unsigned PW = NPCroute + HW;
    localparam int unsigned AW = (NFifo > 1) ? $clog2(NFifo) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (NBlock > 1) ? $clog2(NBlock) : 1;
    localparam int unsigned TW = (NTimeout > 1) ? $clog2(NTimeout) : 1;
    localparam logic [HW-1:0] NOP = {{NPCcode{1'b1}}, {NPCdata{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        PAD    = 2'd2
    } state_t;

    logic [HW-1:0] mem [NFifo];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [BW-1:0] blk;
    logic [HW-1:0] head;
    state_t        state;
    state_t        state_nxt;
    logic          is_local;
    logic          full;
    logic          push;
    logic          xfer;
    logic          pop;
    logic          blk_wrap;
    logic          timeout;

    // Routing split is purely combinational so forwarded words see no latency.
    assign is_local    = (PC_in_d[PW-1 -: NPCroute] == '0);
    assign full        = (count == CW'(NFifo));
    assign PC_in_a     = is_local ? !full : route_out_a;
    assign route_out_v = PC_in_v && !is_local;
    assign route_out_d = PC_in_d;

    assign push       = PC_in_v && is_local && !full;
    assign xfer       = host_out_v && host_out_a;
    assign pop        = xfer && (state != PAD);
    assign blk_wrap   = xfer && (blk == BW'(NBlock - 1));
    assign count_nxt  = count + CW'(push) - CW'(pop);
    assign rd_ptr_nxt = rd_ptr + AW'(pop);

`ifdef PC_OUT_FRAMER_PAD_EN
    logic [TW-1:0] timer;

    assign timeout = (state == STREAM) && (count == '0) && !push && !xfer
                     && (timer == TW'(NTimeout - 1));

    // Idle timer runs only while a partial block is starved of data.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if ((state != STREAM) || push || xfer || timeout) begin
            timer <= '0;
        end else if (count == '0) begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pad_count <= '0;
        end else if (xfer && (state == PAD) && (pad_count != 16'hFFFF)) begin
            pad_count <= pad_count + 16'd1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign pad_count = 16'd0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer && !blk_wrap) state_nxt = STREAM;
            STREAM:  if (blk_wrap) state_nxt = IDLE;
                     else if (timeout) state_nxt = PAD;
            PAD:     if (blk_wrap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Head word stays in the FIFO until transferred, so the output register
    // counts against FIFO capacity; an empty FIFO forwards the pushed word.
    always_comb begin
        head = mem[rd_ptr_nxt];
        if (count_nxt == '0) begin
            head = '0;
        end else if ((count - CW'(pop)) == '0) begin
            head = PC_in_d[HW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= PC_in_d[HW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            blk        <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            host_out_v <= 1'b0;
            host_out_d <= '0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (xfer) begin
                blk <= blk + BW'(1);
            end
            if (state_nxt == PAD) begin
                host_out_v <= 1'b1;
                host_out_d <= NOP;
            end else begin
                host_out_v <= (count_nxt != '0);
                host_out_d <= head;
            end
        end
    end

endmodule
